// File: rtl/param_sync_ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
// Holds the sequencer state encoding and the byte-lane merge.
package param_sync_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Widest word the merge helper handles; callers cast to their width.
    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]   old_w,
        input logic [MAX_W-1:0]   new_w,
        input logic [MAX_W/8-1:0] be
    );
        logic [MAX_W-1:0] w;
        w = old_w;
        for (int i = 0; i < MAX_W / 8; i++) begin
            if (be[i]) begin
                w[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/param_sync_ram_core.sv
// Bare storage array: one byte-masked synchronous write port and a
// registered read of the same address. The array itself is never reset.
module param_sync_ram_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read-first: a same-edge write is not visible in rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/param_sync_ram.sv
// Parametrised single-port RAM with a valid/ready request port, clear
// sequencer, range check, selectable read-during-write and output stage.
module param_sync_ram
    import param_sync_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB = DATA_W / 8;

    state_e            state;
    state_e            state_d;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_d;

    logic              accept;
    logic              in_rng;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              v1;
    logic              err1;
    logic              we1;
    logic [NB-1:0]     be1;
    logic [DATA_W-1:0] wd1;
    logic [DATA_W-1:0] d1;

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign accept    = rst_n & req_valid & req_ready;
    assign in_rng    = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        case (state)
            ST_INIT: begin
                if (clear) begin
                    ptr_d = '0;
                end else if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // The clear sequencer owns the write port while in INIT.
    always_comb begin
        mem_addr  = req_addr;
        mem_be    = req_be;
        mem_wdata = req_wdata;
        mem_we    = accept & req_we & in_rng;
        mem_re    = accept & in_rng;
        if (state == ST_INIT) begin
            mem_addr  = ptr;
            mem_be    = '1;
            mem_wdata = '0;
            mem_we    = rst_n;
            mem_re    = 1'b0;
        end
    end

    param_sync_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            err1 <= 1'b0;
            we1  <= 1'b0;
            be1  <= '0;
            wd1  <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                err1 <= ~in_rng;
                we1  <= req_we;
                be1  <= req_be;
                wd1  <= req_wdata;
            end
        end
    end

    // Stage regs and rdata only move on accept, so d1 holds between responses.
    always_comb begin
        d1 = mem_rdata;
        if (err1) begin
            d1 = '0;
        end else if (RDW_MODE == 1 && we1) begin
            d1 = DATA_W'(merge_bytes(MAX_W'(mem_rdata), MAX_W'(wd1),
                                     (MAX_W / 8)'(be1)));
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              v2;
        logic              e2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                e2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    e2 <= err1;
                    d2 <= d1;
                end
            end
        end

        assign rsp_valid = v2;
        assign rsp_rdata = d2;
        assign rsp_err   = e2;
    end else begin : g_noreg
        assign rsp_valid = v1;
        assign rsp_rdata = d1;
        assign rsp_err   = err1;
    end

endmodule

// File: tb/tb_param_sync_ram.sv
// Bench for param_sync_ram: two configurations run in lockstep against
// an array/queue reference model of the memory and its responses.
module tb_param_sync_ram;

    localparam int DEP [2] = '{6, 8};
    localparam int LAT [2] = '{0, 1};
    localparam int RDW [2] = '{0, 1};
    localparam int NBE [2] = '{4, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy_a, rv_a, re_a, id_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, re_b, id_b;
    logic [7:0]  rd_b;

    always #5 clk = ~clk;

    // A: 32-bit, depth 6, read-first, no output reg.
    param_sync_ram #(
        .DATA_W(32), .DEPTH(6), .ADDR_W(3), .RDW_MODE(0), .OUT_REG(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(re_a),
        .init_done(id_a)
    );

    // B: 8-bit, depth 8, write-through, output reg.
    param_sync_ram #(
        .DATA_W(8), .DEPTH(8), .ADDR_W(3), .RDW_MODE(1), .OUT_REG(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be[0:0]),
        .req_wdata(req_wdata[7:0]),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(re_b),
        .init_done(id_b)
    );

    logic        ob_v [2];
    logic        ob_e [2];
    logic        ob_r [2];
    logic        ob_i [2];
    logic [31:0] ob_d [2];

    assign ob_v[0] = rv_a;
    assign ob_v[1] = rv_b;
    assign ob_e[0] = re_a;
    assign ob_e[1] = re_b;
    assign ob_r[0] = rdy_a;
    assign ob_r[1] = rdy_b;
    assign ob_i[0] = id_a;
    assign ob_i[1] = id_b;
    assign ob_d[0] = rd_a;
    assign ob_d[1] = {24'h0, rd_b};

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic [31:0] mm [2][8];
    bit          mready [2];
    int          mcnt [2];
    rsp_t        qa [$];
    rsp_t        qb [$];
    logic        ev [2];
    logic        ee [2];
    logic        er [2];
    logic [31:0] ed [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic model_edge(input int k);
        rsp_t        r;
        logic [31:0] old;
        logic [31:0] mrg;
        bit          hit;
        if (!rst_n) begin
            mready[k] = 0;
            mcnt[k]   = DEP[k];
            if (k == 0) qa.delete();
            else qb.delete();
            ev[k] = 1'b0;
            ed[k] = '0;
            ee[k] = 1'b0;
            er[k] = 1'b0;
            return;
        end
        if (mready[k] && req_valid) begin
            r.due = cyc + LAT[k];
            r.e   = (int'(req_addr) >= DEP[k]);
            r.d   = '0;
            if (!r.e) begin
                old = mm[k][req_addr];
                mrg = old;
                for (int i = 0; i < NBE[k]; i++)
                    if (req_be[i]) mrg[i*8 +: 8] = req_wdata[i*8 +: 8];
                if (req_we) mm[k][req_addr] = mrg;
                r.d = (req_we && RDW[k] != 0) ? mrg : old;
            end
            if (k == 0) qa.push_back(r);
            else qb.push_back(r);
        end
        if (mready[k]) begin
            if (clear) begin
                mready[k] = 0;
                mcnt[k]   = DEP[k];
            end
        end else if (clear) begin
            mcnt[k] = DEP[k];
        end else begin
            mcnt[k]--;
            if (mcnt[k] == 0) begin
                mready[k] = 1;
                for (int a = 0; a < 8; a++) mm[k][a] = '0;
            end
        end
        hit = 0;
        if (k == 0) begin
            if (qa.size() != 0 && qa[0].due == cyc) begin
                r = qa.pop_front();
                hit = 1;
            end
        end else begin
            if (qb.size() != 0 && qb[0].due == cyc) begin
                r = qb.pop_front();
                hit = 1;
            end
        end
        ev[k] = hit;
        if (hit) begin
            ed[k] = r.d;
            ee[k] = r.e;
        end
        er[k] = mready[k];
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit we, input int a,
                         input logic [3:0] be, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = 3'(a);
        req_be    = be;
        req_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 3, 4'hF, 32'hDEADBEEF);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ob_v[k] !== 1'b0 || ob_d[k] !== 32'h0 || ob_e[k] !== 1'b0
                || ob_r[k] !== 1'b0 || ob_i[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: v=%b d=%h e=%b rdy=%b done=%b want all 0",
                         k, ob_v[k], ob_d[k], ob_e[k], ob_r[k], ob_i[k]);
            end
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 4'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_i[k] !== er[k]
                    || ob_r[k] !== er[k]) begin
                    bad++;
                    $display("FAIL init_seq dut%0d cyc=%0d: v=%b done=%b rdy=%b want v=%b done=%b",
                             k, cyc, ob_v[k], ob_i[k], ob_r[k], ev[k], er[k]);
                end
            end
        end
    endtask

    task automatic test_idle_reads();
        for (int a = 0; a < 10; a++) begin
            if (a < 8) drive(1, 0, a, 4'h0, 32'h0);
            else drive(0, 0, 0, 4'h0, 32'h0);
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL idle_read dut%0d cyc=%0d: v=%b d=%h e=%b want v=%b d=%h e=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ev[k], ed[k], ee[k]);
                end
            end
        end
    endtask

    task automatic test_byte_enables();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: drive(1, 1, 3, 4'b1111, 32'hAABBCCDD);
                1: drive(1, 1, 3, 4'b0101, 32'h11223344);
                2: drive(1, 0, 3, 4'b0000, 32'h0);
                default: drive(0, 0, 0, 4'h0, 32'h0);
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL byte_en dut%0d cyc=%0d: v=%b d=%h e=%b want v=%b d=%h e=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ev[k], ed[k], ee[k]);
                end
            end
            if (s == 2) begin
                total++;
                if (rv_a !== 1'b1 || rd_a !== 32'hAA22CC44) begin
                    bad++;
                    $display("FAIL byte_en_word: v=%b d=%h want v=1 d=aa22cc44",
                             rv_a, rd_a);
                end
            end
        end
    endtask

    task automatic test_rdw();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(1, 1, 5, 4'hF, 32'h12);
                1: drive(1, 1, 5, 4'hF, 32'h34);
                2: drive(1, 0, 5, 4'h0, 32'h0);
                default: drive(0, 0, 0, 4'h0, 32'h0);
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL rdw dut%0d cyc=%0d: v=%b d=%h e=%b want v=%b d=%h e=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ev[k], ed[k], ee[k]);
                end
            end
            if (s == 1) begin
                total++;
                if (rv_a !== 1'b1 || rd_a !== 32'h12) begin
                    bad++;
                    $display("FAIL rdw_old: v=%b d=%h want v=1 d=12", rv_a, rd_a);
                end
            end
            if (s == 2) begin
                total++;
                if (rv_b !== 1'b1 || rd_b !== 8'h34) begin
                    bad++;
                    $display("FAIL rdw_new: v=%b d=%h want v=1 d=34", rv_b, rd_b);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int s = 0; s < 10; s++) begin
            case (s)
                0: drive(1, 1, 7, 4'hF, 32'hFF);
                1: drive(1, 0, 7, 4'h0, 32'h0);
                2, 3, 4, 5, 6, 7: drive(1, 0, s - 2, 4'h0, 32'h0);
                default: drive(0, 0, 0, 4'h0, 32'h0);
            endcase
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]) begin
                    bad++;
                    $display("FAIL range dut%0d cyc=%0d: v=%b d=%h e=%b want v=%b d=%h e=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ev[k], ed[k], ee[k]);
                end
            end
            if (s == 0) begin
                total++;
                if (rv_a !== 1'b1 || re_a !== 1'b1 || rd_a !== 32'h0) begin
                    bad++;
                    $display("FAIL range_err: v=%b e=%b d=%h want v=1 e=1 d=0",
                             rv_a, re_a, rd_a);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), 4'($urandom), $urandom);
            clear = ($urandom_range(0, 49) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]
                    || ob_r[k] !== er[k]) begin
                    bad++;
                    $display("FAIL b2b dut%0d cyc=%0d: v=%b d=%h e=%b rdy=%b want v=%b d=%h e=%b rdy=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ob_r[k],
                             ev[k], ed[k], ee[k], er[k]);
                end
            end
        end
        clear = 1'b0;
        drive(0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_clear_midstream();
        int lo_b;
        int waited;
        waited = 0;
        while (!(mready[0] && mready[1]) && waited < 40) begin
            step();
            waited++;
        end
        total++;
        if (!(mready[0] && mready[1])) begin
            bad++;
            $display("FAIL clear_wait: ready not reached in %0d cycles", waited);
        end
        lo_b = 0;
        for (int s = 0; s < 30; s++) begin
            clear = 1'b0;
            if (s < 4) drive(1, 1, s, 4'hF, 32'hC0DE0000 + s);
            else drive(1, 0, s % 8, 4'h0, 32'h0);
            if (s == 7) clear = 1'b1;
            step();
            if (s >= 7 && ob_r[1] === 1'b0) lo_b++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]
                    || ob_r[k] !== er[k]) begin
                    bad++;
                    $display("FAIL clear dut%0d cyc=%0d: v=%b d=%h e=%b rdy=%b want v=%b d=%h e=%b rdy=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ob_r[k],
                             ev[k], ed[k], ee[k], er[k]);
                end
            end
        end
        clear = 1'b0;
        total++;
        if (lo_b != 8) begin
            bad++;
            $display("FAIL clear_ready_low: cycles=%0d want 8", lo_b);
        end
        drive(0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 40; s++) begin
            clear = (s == 0);
            rst_n = !(s == 3 || s == 22);
            if (s >= 18 && s < 24) drive(1, 0, s % 8, 4'h0, 32'h0);
            else if (s >= 12 && s < 18) drive(1, 1, s % 8, 4'hF, $urandom);
            else drive(0, 0, 0, 4'h0, 32'h0);
            step();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ob_v[k] !== ev[k] || ob_d[k] !== ed[k] || ob_e[k] !== ee[k]
                    || ob_i[k] !== er[k]) begin
                    bad++;
                    $display("FAIL rst_mid dut%0d cyc=%0d: v=%b d=%h e=%b done=%b want v=%b d=%h e=%b done=%b",
                             k, cyc, ob_v[k], ob_d[k], ob_e[k], ob_i[k],
                             ev[k], ed[k], ee[k], er[k]);
                end
            end
        end
        rst_n = 1'b1;
        clear = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0;
            ee[k] = 1'b0;
            er[k] = 1'b0;
            ed[k] = '0;
            mready[k] = 0;
            mcnt[k] = DEP[k];
        end
        @(negedge clk);
        test_reset();
        test_idle_reads();
        test_byte_enables();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_clear_midstream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_sync_ram.md
# param_sync_ram

Parametrised single-port synchronous RAM: the next generation of the team's fixed 8x8 RAM. Adds configurable width and depth, per-byte write enables, a valid/ready request port, a response-valid strobe with selectable read-during-write behaviour, an optional output register, out-of-range detection, and a hardware clear sequencer that zeroes the array after reset or on request. Used as the general scratch/buffer memory behind the register and datapath blocks.

## Interface
- DATA_W, 8: word width; must be a multiple of 8.
- DEPTH, 8: number of words; any value ≥ 2, not necessarily a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- RDW_MODE, 0: data returned on a write. 0 = old word (read-first); 1 = merged new word (write-through).
- OUT_REG, 0: 1 adds one output pipeline stage.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clear  in  1  pulse; restart the zeroing sequence
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_be  in  DATA_W/8  byte enables, writes only
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle strobe per accepted request
- rsp_rdata  out  DATA_W  response data
- rsp_err  out  1  qualifies rsp_valid; address ≥ DEPTH
- init_done  out  1  high once clearing completes

## Operation
- States: INIT, RUN.
- Reset, rst_n low at an edge: state INIT, clear pointer 0, all pipeline valids 0, and all outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, init_done. The reset does not write the array itself.
- INIT: each cycle writes 0 to mem[ptr] and increments ptr. After writing DEPTH-1, go to RUN and set init_done=1. req_ready=0 throughout.
- RUN: req_ready=1. clear=1 in RUN moves to INIT with ptr=0 and init_done=0 on the next edge. A request in that same cycle is accepted.
- clear asserted during INIT restarts ptr at 0.
- Read: response carries mem[addr].
- Write with addr < DEPTH: each byte lane i with req_be[i]=1 is updated from req_wdata; other lanes keep their value.
  - RDW_MODE=0: response carries the pre-write word.
  - RDW_MODE=1: response carries the merged word.
- Write with req_be all zero: the array is unchanged and a response is still returned.
- Address ≥ DEPTH: no array access. Response has rsp_rdata=0 and rsp_err=1.
- Every accepted request produces exactly one response, in order. There is no response backpressure.
- Responses already in flight when clear or INIT entry occurs are still delivered.
- rsp_rdata and rsp_err hold their last values when rsp_valid=0.
- Back-to-back requests at full rate; a read following a write to the same address returns the written data.

## Timing
- Request accepted at edge N: rsp_valid high in the cycle after edge N+OUT_REG, i.e. latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Clear sequence: with rst_n first sampled high at edge 1, edges 1..DEPTH zero the array. init_done and req_ready are high from edge DEPTH onward, so the first accept is possible at edge DEPTH+1.
- rst_n low mid-operation: all in-flight responses are dropped, no rsp_valid follows, and INIT restarts.
- Throughput: one request per cycle in RUN.

## Structure
- Package param_sync_ram_pkg holds:
  - the state enum (ST_INIT, ST_RUN);
  - the byte-merge function (old, new, be) -> word.
- Sub-module param_sync_ram_core: the bare storage array with one synchronous write port (addr, be, data) and a read port returning mem[addr] registered. No reset on the array.
- The top level holds the FSM, clear pointer, mux between the init write and the request write, range check, RDW select, and the optional output stage.

## Test plan
- Reset then idle, DEPTH=8: init_done rises at edge 8. Read every address: all responses 0, rsp_err=0, latency 1.
- DATA_W=32: write 0xAABBCCDD to addr 3 with be=4'b1111. Write 0x11223344 to addr 3 with be=4'b0101. Read addr 3 -> 0xAA22CC44.
- RDW_MODE=0 vs RDW_MODE=1: addr 5 holds 0x12; write 0x34 to it. The write response is 0x12 (mode 0) or 0x34 (mode 1). A back-to-back read returns 0x34 in both modes.
- DEPTH=6, ADDR_W=3: write 0xFF to addr 7 -> rsp_err=1, rsp_rdata=0. Read addr 7 -> rsp_err=1. Addresses 0-5 unchanged.
- OUT_REG=1, 4 consecutive reads: rsp_valid high 2 cycles after each accept, in order. Assert clear mid-stream: pending responses still arrive, req_ready low for DEPTH cycles, then all reads return 0.
- rst_n low for 1 cycle during INIT and during in-flight reads: no stray rsp_valid, and init_done rises exactly DEPTH edges after reset release.
